// File: rtl/serial_twos_comp_mc.sv
// serial_twos_comp_mc
//   Multi-lane bit-serial two's-complement negator. CH independent LSB-first
//   lanes share one framing: WIDTH-bit words, start marked by in_sof. Each lane
//   negates its word when its neg_en bit was set on the SOF bit. The module also
//   assembles a parallel copy of the result, flags negation overflow and
//   reports an SOF that arrives before the current word has finished.
// Ports
//   t_clk    : clock, rising edge
//   r        : asynchronous active-high reset
//   in_valid : input bits on i are valid this cycle (all lanes)
//   in_sof   : start of word (bit 0), qualified by in_valid
//   i        : serial input bit per lane, LSB first
//   neg_en   : per-lane negate enable, sampled on an accepted SOF bit
//   y        : serial output bit per lane, one cycle after acceptance
//   y_valid  : y valid
//   y_eow    : y carries the MSB of the word
//   word_out : parallel result, lane k in [k*WIDTH +: WIDTH]
//   word_vld : one-cycle pulse when word_out is updated
//   ovf      : per-lane negation overflow, valid with word_vld
//   sof_err  : one-cycle pulse when an SOF aborts an unfinished word
module serial_twos_comp_mc #(
    parameter int WIDTH = 8,
    parameter int CH    = 2
) (
    input  logic                t_clk,
    input  logic                r,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic [CH-1:0]       i,
    input  logic [CH-1:0]       neg_en,
    output logic [CH-1:0]       y,
    output logic                y_valid,
    output logic                y_eow,
    output logic [CH*WIDTH-1:0] word_out,
    output logic                word_vld,
    output logic [CH-1:0]       ovf,
    output logic                sof_err
);

    localparam int CNTW = $clog2(WIDTH);
    localparam logic [CNTW-1:0] CNT_MSB = CNTW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_nxt;
    logic [CNTW-1:0]     cnt, cnt_nxt;
    logic [CH-1:0]       neg_q, neg_nxt;
    logic [CH-1:0]       seen_q, seen_nxt;
    logic [CH-1:0]       out_bit, ovf_bit;
    logic [CH*WIDTH-1:0] acc, acc_nxt;
    logic                accept, is_sof, mid_sof, is_msb;

    always_ff @(posedge t_clk or posedge r) begin
        if (r) state <= IDLE;
        else   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        neg_nxt   = neg_q;
        seen_nxt  = seen_q;
        acc_nxt   = acc;
        out_bit   = '0;
        ovf_bit   = '0;

        is_sof  = in_valid & in_sof;
        accept  = in_valid & (in_sof | (state == SHIFT));
        mid_sof = is_sof & (state == SHIFT);
        // An SOF always wins over completing a word, even on the MSB cycle.
        is_msb  = accept & ~is_sof & (cnt == CNT_MSB);

        if (is_sof) begin
            state_nxt = SHIFT;
            cnt_nxt   = CNTW'(1);
            neg_nxt   = neg_en;
            acc_nxt   = '0;
        end else if (accept) begin
            if (cnt == CNT_MSB) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CNTW'(1);
            end
        end

        // Serial negation: copy bits up to and including the first 1, then invert.
        for (int unsigned k = 0; k < CH; k++) begin
            if (is_sof) begin
                out_bit[k]          = i[k];
                seen_nxt[k]         = i[k];
                acc_nxt[k*WIDTH]    = i[k];
            end else if (accept) begin
                out_bit[k]  = (neg_q[k] & seen_q[k]) ? ~i[k] : i[k];
                seen_nxt[k] = seen_q[k] | i[k];
                acc_nxt[k*WIDTH + 32'(cnt)] = out_bit[k];
                // Only the most negative value has no 1 below a set MSB.
                ovf_bit[k]  = neg_q[k] & ~seen_q[k] & i[k];
            end
        end
    end

    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            cnt      <= '0;
            neg_q    <= '0;
            seen_q   <= '0;
            acc      <= '0;
            y        <= '0;
            y_valid  <= 1'b0;
            y_eow    <= 1'b0;
            word_out <= '0;
            word_vld <= 1'b0;
            ovf      <= '0;
            sof_err  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            neg_q    <= neg_nxt;
            seen_q   <= seen_nxt;
            acc      <= acc_nxt;
            y_valid  <= accept;
            y_eow    <= is_msb;
            word_vld <= is_msb;
            sof_err  <= mid_sof;
            if (accept) y <= out_bit;
            if (is_msb) begin
                word_out <= acc_nxt;
                ovf      <= ovf_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_twos_comp_mc.sv
// tb_serial_twos_comp_mc
//   Directed bench for serial_twos_comp_mc with WIDTH=4, CH=2. Stimulus pushes
//   expected serial beats, words and framing errors into queues; a monitor on
//   the falling edge pops and compares whenever the DUT presents an output.
module tb_serial_twos_comp_mc;

    localparam int W = 4;
    localparam int C = 2;

    logic         t_clk = 1'b0;
    logic         r = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sof = 1'b0;
    logic [C-1:0] i = '0;
    logic [C-1:0] neg_en = '0;
    logic [C-1:0] y;
    logic         y_valid, y_eow, word_vld, sof_err;
    logic [C*W-1:0] word_out;
    logic [C-1:0] ovf;

    serial_twos_comp_mc #(.WIDTH(W), .CH(C)) dut (
        .t_clk(t_clk), .r(r), .in_valid(in_valid), .in_sof(in_sof), .i(i),
        .neg_en(neg_en), .y(y), .y_valid(y_valid), .y_eow(y_eow),
        .word_out(word_out), .word_vld(word_vld), .ovf(ovf), .sof_err(sof_err)
    );

    always #5 t_clk = ~t_clk;

    typedef struct packed { logic [1:0] y; logic eow; } beat_t;
    typedef struct packed { logic [7:0] w; logic [1:0] o; } word_t;

    beat_t       yq[$];
    word_t       wq[$];
    int          sof_exp = 0;
    int unsigned cyc = 0;
    int unsigned vt[$];
    int          compared = 0;
    int          mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge t_clk) cyc++;

    always @(negedge t_clk) begin
        if (!r) begin
            if (y_valid) begin
                check("y_expected", 32'(yq.size() != 0), 32'd1);
                if (yq.size() != 0) begin
                    beat_t b;
                    b = yq.pop_front();
                    check("y", 32'(y), 32'(b.y));
                    check("y_eow", 32'(y_eow), 32'(b.eow));
                end
            end
            if (word_vld) begin
                vt.push_back(cyc);
                check("word_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    word_t e;
                    e = wq.pop_front();
                    check("word_out", 32'(word_out), 32'(e.w));
                    check("ovf", 32'(ovf), 32'(e.o));
                end
            end
            if (sof_err) begin
                check("sof_err_expected", 32'(sof_exp > 0), 32'd1);
                if (sof_exp > 0) sof_exp--;
            end
        end
    end

    task automatic drive(input logic sof, input logic [1:0] bits, input logic [1:0] ne);
        in_valid = 1'b1; in_sof = sof; i = bits; neg_en = ne;
        @(posedge t_clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send(input logic sof, input logic [1:0] bits, input logic [1:0] ne,
                        input logic [1:0] ey, input logic eow);
        yq.push_back(beat_t'{y: ey, eow: eow});
        drive(sof, bits, ne);
    endtask

    task automatic gap();
        in_valid = 1'b0; in_sof = 1'b0;
        i = 2'($urandom); neg_en = 2'($urandom);
        @(posedge t_clk); #1;
    endtask

    task automatic exp_word(input logic [7:0] w, input logic [1:0] o);
        wq.push_back(word_t'{w: w, o: o});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_y"}, 32'(y), 32'd0);
        check({tag, "_y_valid"}, 32'(y_valid), 32'd0);
        check({tag, "_y_eow"}, 32'(y_eow), 32'd0);
        check({tag, "_word_out"}, 32'(word_out), 32'd0);
        check({tag, "_word_vld"}, 32'(word_vld), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        check({tag, "_sof_err"}, 32'(sof_err), 32'd0);
    endtask

    initial begin
        // Reset state, with garbage on the inputs.
        in_valid = 1'b1; in_sof = 1'b1; i = 2'b11; neg_en = 2'b11;
        #12;
        check_all_zero("reset");
        in_valid = 1'b0; in_sof = 1'b0;
        @(negedge t_clk); #2; r = 1'b0;
        @(posedge t_clk); #1;

        // 1: lane0 negates 3 -> 1101, lane1 passes 3 -> 0011.
        send(1, 2'b11, 2'b01, 2'b11, 0);
        send(0, 2'b11, 2'b01, 2'b10, 0);
        send(0, 2'b00, 2'b01, 2'b01, 0);
        send(0, 2'b00, 2'b01, 2'b01, 1);
        exp_word(8'h3D, 2'b00);
        gap();

        // 2: lane0 -8 overflows; ovf holds; next all-zero word clears it.
        send(1, 2'b00, 2'b01, 2'b00, 0);
        send(0, 2'b00, 2'b01, 2'b00, 0);
        send(0, 2'b00, 2'b01, 2'b00, 0);
        send(0, 2'b01, 2'b01, 2'b01, 1);
        exp_word(8'h08, 2'b01);
        gap();
        check("ovf_hold", 32'(ovf), 32'h1);
        check("word_hold", 32'(word_out), 32'h08);
        send(1, 2'b00, 2'b11, 2'b00, 0);
        send(0, 2'b00, 2'b11, 2'b00, 0);
        send(0, 2'b00, 2'b11, 2'b00, 0);
        send(0, 2'b00, 2'b11, 2'b00, 1);
        exp_word(8'h00, 2'b00);
        gap();

        // 3: 0101 with 3 idle cycles after bit 1; lane0 -> 1011, lane1 -> 0101.
        send(1, 2'b11, 2'b01, 2'b11, 0);
        send(0, 2'b00, 2'b01, 2'b01, 0);
        gap(); gap(); gap();
        send(0, 2'b11, 2'b01, 2'b10, 0);
        send(0, 2'b00, 2'b01, 2'b01, 1);
        exp_word(8'h5B, 2'b00);
        gap();

        // 4: SOF at bit 2 aborts; new word lane0 -6 -> 1010, lane1 1 -> 0001.
        send(1, 2'b11, 2'b00, 2'b11, 0);
        send(0, 2'b01, 2'b00, 2'b01, 0);
        sof_exp++;
        send(1, 2'b10, 2'b01, 2'b10, 0);
        send(0, 2'b01, 2'b10, 2'b01, 0);
        send(0, 2'b01, 2'b10, 2'b00, 0);
        send(0, 2'b00, 2'b10, 2'b01, 1);
        exp_word(8'h1A, 2'b00);
        gap();

        // 4b: SOF on the MSB cycle aborts too; new word negates 1 on both lanes.
        send(1, 2'b11, 2'b00, 2'b11, 0);
        send(0, 2'b11, 2'b00, 2'b11, 0);
        send(0, 2'b11, 2'b00, 2'b11, 0);
        sof_exp++;
        send(1, 2'b11, 2'b11, 2'b11, 0);
        send(0, 2'b00, 2'b00, 2'b11, 0);
        send(0, 2'b00, 2'b00, 2'b11, 0);
        send(0, 2'b00, 2'b00, 2'b11, 1);
        exp_word(8'hFF, 2'b00);
        gap();

        // 5: asynchronous reset mid-word, then non-SOF bits are ignored.
        send(1, 2'b11, 2'b11, 2'b11, 0);
        send(0, 2'b01, 2'b11, 2'b10, 0);
        @(negedge t_clk); #1;
        r = 1'b1;
        #1;
        check_all_zero("async_rst");
        #1;
        r = 1'b0;
        @(posedge t_clk); #1;
        drive(0, 2'b11, 2'b11);
        drive(0, 2'b01, 2'b11);
        gap();
        // lane0 1 passes -> 0001, lane1 4 negated -> 1100.
        send(1, 2'b01, 2'b10, 2'b01, 0);
        send(0, 2'b00, 2'b10, 2'b00, 0);
        send(0, 2'b10, 2'b10, 2'b10, 0);
        send(0, 2'b00, 2'b10, 2'b10, 1);
        exp_word(8'hC1, 2'b00);
        gap();

        // 6: neg_en toggled mid-word has no effect; back-to-back words.
        vt.delete();
        send(1, 2'b10, 2'b01, 2'b10, 0);
        send(0, 2'b11, 2'b10, 2'b11, 0);
        send(0, 2'b00, 2'b10, 2'b01, 0);
        send(0, 2'b00, 2'b10, 2'b01, 1);
        exp_word(8'h3E, 2'b00);
        send(1, 2'b11, 2'b10, 2'b11, 0);
        send(0, 2'b00, 2'b01, 2'b10, 0);
        send(0, 2'b00, 2'b01, 2'b10, 0);
        send(0, 2'b00, 2'b01, 2'b10, 1);
        exp_word(8'hF1, 2'b00);
        gap(); gap(); gap();
        check("b2b_vld_count", 32'(vt.size()), 32'd2);
        if (vt.size() == 2) check("b2b_vld_spacing", vt[1] - vt[0], 32'd4);

        check("y_left", 32'(yq.size()), 32'd0);
        check("word_left", 32'(wq.size()), 32'd0);
        check("sof_err_left", 32'(sof_exp), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
